// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for cpu_ctrl_fsm
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXEC_R  = 3'd3,
        ST_LOAD    = 3'd4,
        ST_LOAD_WB = 3'd5,
        ST_STORE   = 3'd6,
        ST_JUMP    = 3'd7
    } state_t;

    // Major opcode selecting the memory/jump group; everything else is R-type.
    localparam logic [3:0] OP_SPECIAL = 4'b0100;

    // Sub-op field ir[7:4] within the special group.
    localparam logic [3:0] SUB_LOAD  = 4'b0000;
    localparam logic [3:0] SUB_STORE = 4'b0100;
    localparam logic [3:0] SUB_JCOND = 4'b1100;

    // Jump condition codes carried in ir[11:8].
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_UC = 4'b1110;

    // Bit positions in the ALU flag vector.
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // True when the jump condition holds for the given flags; unlisted codes never jump.
    function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] f);
        logic r;
        r = 1'b0;
        case (cond)
            COND_EQ: r =  f[FLAG_Z];
            COND_NE: r = ~f[FLAG_Z];
            COND_CS: r =  f[FLAG_C];
            COND_CC: r = ~f[FLAG_C];
            COND_HI: r =  f[FLAG_L];
            COND_LS: r = ~f[FLAG_L];
            COND_GT: r =  f[FLAG_N];
            COND_LE: r = ~f[FLAG_N];
            COND_FS: r =  f[FLAG_F];
            COND_FC: r = ~f[FLAG_F];
            COND_UC: r =  1'b1;
            default: r =  1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// rtl/reg_onehot_dec.sv - 4-bit register index to one-hot write enable, zero when out of range
module reg_onehot_dec #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx,
    output logic [NREGS-1:0] onehot
);

    // Indices at or above NREGS match no bit, so the write is silently dropped.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == 4'(i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/execute controller; CTRL_JCOND_EN enables conditional jumps
module cpu_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      mem_in,
    input  logic             mem_ready,
    input  logic [4:0]       flags,
    output logic [15:0]      opcode,
    output logic [3:0]       mux_a_sel,
    output logic [3:0]       mux_b_sel,
    output logic [NREGS-1:0] reg_en,
    output logic             alu_sel,
    output logic             pc_sel,
    output logic             mem_w_en_a,
    output logic             flag_en,
    output logic             pc_en,
    output logic             pc_load,
    output logic             illegal
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]       op, sub_op, rdest, rsrc;
    logic             is_special, dec_illegal, reg_wr;
    logic [NREGS-1:0] dest_onehot;

    assign op         = ir_q[15:12];
    assign rdest      = ir_q[11:8];
    assign sub_op     = ir_q[7:4];
    assign rsrc       = ir_q[3:0];
    assign is_special = (op == OP_SPECIAL);
    assign opcode     = ir_q;

`ifdef CTRL_JCOND_EN
    assign dec_illegal = is_special && (sub_op != SUB_LOAD) && (sub_op != SUB_STORE)
                                    && (sub_op != SUB_JCOND);
`else
    // Flags only steer jumps, which this build does not decode.
    logic unused_flags;
    assign unused_flags = ^flags;
    assign dec_illegal  = is_special && (sub_op != SUB_LOAD) && (sub_op != SUB_STORE);
`endif

    reg_onehot_dec #(.NREGS(NREGS)) u_dest_dec (
        .idx    (rdest),
        .onehot (dest_onehot)
    );

    // Next-state and instruction-register capture.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_in;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!is_special) begin
                    state_d = ST_EXEC_R;
                end else begin
                    case (sub_op)
                        SUB_LOAD:  state_d = ST_LOAD;
                        SUB_STORE: state_d = ST_STORE;
`ifdef CTRL_JCOND_EN
                        SUB_JCOND: state_d = ST_JUMP;
`endif
                        default:   state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC_R:  state_d = ST_FETCH;
            ST_LOAD:    if (mem_ready) state_d = ST_LOAD_WB;
            ST_LOAD_WB: state_d = ST_FETCH;
            ST_STORE:   if (mem_ready) state_d = ST_FETCH;
            default:    state_d = ST_FETCH;
        endcase
    end

    // State and instruction register; reset clears both.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Control outputs decoded from state and ir; reset masks every enable immediately.
    always_comb begin
        mux_a_sel  = 4'd0;
        mux_b_sel  = 4'd0;
        reg_wr     = 1'b0;
        alu_sel    = 1'b1;
        pc_sel     = 1'b1;
        mem_w_en_a = 1'b0;
        flag_en    = 1'b0;
        pc_en      = 1'b0;
        pc_load    = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            ST_FETCH:  pc_en = mem_ready;
            ST_DECODE: illegal = dec_illegal;
            ST_EXEC_R: begin
                mux_a_sel = rdest;
                mux_b_sel = rsrc;
                reg_wr    = 1'b1;
                flag_en   = 1'b1;
            end
            ST_STORE: begin
                mux_a_sel  = rsrc;
                mux_b_sel  = rdest;
                pc_sel     = 1'b0;
                mem_w_en_a = 1'b1;
            end
            ST_LOAD: begin
                mux_a_sel = rsrc;
                pc_sel    = 1'b0;
            end
            ST_LOAD_WB: begin
                mux_a_sel = rsrc;
                pc_sel    = 1'b0;
                alu_sel   = 1'b0;
                reg_wr    = 1'b1;
            end
`ifdef CTRL_JCOND_EN
            ST_JUMP: begin
                mux_a_sel = rsrc;
                pc_load   = cond_met(rdest, flags);
            end
`endif
            default: ;
        endcase
        if (reset) begin
            reg_wr     = 1'b0;
            mem_w_en_a = 1'b0;
            flag_en    = 1'b0;
            pc_en      = 1'b0;
            pc_load    = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign reg_en = reg_wr ? dest_onehot : '0;

endmodule
